gpr_file_mp: RTL and testbench

Parametrised general-purpose register file for the RISC-V core. It generalises the fixed two-read-port GPR file with configurable XLEN, register count (RV32I/RV32E), and read-port count. It adds a pending-write scoreboard for hazard detection and a handshaked debug/bus access port arbitrated against core writeback. It sits between decode (read ports, issue), writeback (write port) and the debug bus.

---
 rtl/gpr_file_mp_pkg.sv | 29 ++
 rtl/gpr_scoreboard.sv | 62 ++++++
 rtl/gpr_file_mp.sv | 143 ++++++++++++++
 tb/tb_gpr_file_mp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_file_mp_pkg.sv
// -----------------------------------------------------------------------------
// gpr_file_mp_pkg
// Shared defines for the parametrised GPR file: default XLEN, the base-ISA
// selection of the register count (RV32I = 32 regs, RV32E = 16 regs), the
// derived address width, the debug FSM state encodings and an address
// range helper.
// Configuration macro used by the importers: GPR_BYPASS_EN.
// -----------------------------------------------------------------------------
package gpr_file_mp_pkg;

   // 1 = RV32I (32 GPRs), 0 = RV32E (16 GPRs)
   localparam bit RV32I_BASE_ISA = 1'b1;

   localparam int GPR_XLEN  = 32;
   localparam int GPR_NREGS = RV32I_BASE_ISA ? 32 : 16;
   localparam int GPR_AW    = $clog2(GPR_NREGS);

   typedef enum logic [1:0] {
      DBG_IDLE = 2'd0,
      DBG_WAIT = 2'd1,
      DBG_DONE = 2'd2
   } dbg_state_e;

   // Addresses at or above the register count read 0 and drop writes.
   function automatic bit addr_ok(input int a, input int nregs);
      return a < nregs;
   endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// -----------------------------------------------------------------------------
// gpr_scoreboard
// Pending-write bits, one per GPR. An issued instruction marks its destination
// pending; the matching writeback clears it. When both hit the same register
// in one cycle the set wins, since the newly issued producer is still
// outstanding. x0 is never pending.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   issue_i, issue_rd_i destination issue (sets pend)
//   we_i, waddr_i       core writeback (clears pend)
//   raddr_i             packed read addresses, port k at [k*AW +: AW]
//   busy_o              per-port pending flag
// Macro GPR_BYPASS_EN: a writeback to the read register in the current cycle
// masks busy, unless the same cycle also re-issues that register.
// -----------------------------------------------------------------------------
module gpr_scoreboard
   import gpr_file_mp_pkg::*;
#(
   parameter int NREGS = GPR_NREGS,
   parameter int NRP   = 2,
   localparam int AW   = $clog2(NREGS)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_i,
   input  logic [AW-1:0]     issue_rd_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [NRP*AW-1:0] raddr_i,
   output logic [NRP-1:0]    busy_o
);

   logic [NREGS-1:0] pend;

   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
      end else begin
         pend[0] <= 1'b0;
         for (int i = 1; i < NREGS; i++) begin
            if (issue_i && issue_rd_i == AW'(i))
               pend[i] <= 1'b1;
            else if (we_i && waddr_i == AW'(i))
               pend[i] <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < NRP; k++) begin : g_busy
      logic [AW-1:0] ra;
      logic          pend_hit;
      assign ra       = raddr_i[k*AW +: AW];
      assign pend_hit = addr_ok(int'(ra), NREGS) ? pend[ra] : 1'b0;
`ifdef GPR_BYPASS_EN
      assign busy_o[k] = (we_i && waddr_i == ra && ra != '0) ?
                         (issue_i && issue_rd_i == ra) : pend_hit;
`else
      assign busy_o[k] = pend_hit;
`endif
   end

endmodule

// File: rtl/gpr_file_mp.sv
// -----------------------------------------------------------------------------
// gpr_file_mp
// Parametrised RISC-V GPR file: NREGS x XLEN storage, NRP combinational read
// ports, one core writeback port, a pending-write scoreboard and a handshaked
// debug access port that yields to core writeback.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   raddr_i / rdata_o        packed read addresses / read data per port
//   busy_o                   per-port pending-write flag
//   we_i, waddr_i, wdata_i   core writeback
//   issue_i, issue_rd_i      destination issue into the scoreboard
//   dbg_req_i .. dbg_wdata_i debug request, held until dbg_ack_o
//   dbg_ack_o                one-cycle completion pulse
//   dbg_rdata_o              debug read data, held until the next ack
// Macro GPR_BYPASS_EN: forward same-cycle writeback data to matching read
// ports. Undefined, reads return the stored value.
// -----------------------------------------------------------------------------
module gpr_file_mp
   import gpr_file_mp_pkg::*;
#(
   parameter int XLEN  = GPR_XLEN,
   parameter int NREGS = GPR_NREGS,
   parameter int NRP   = 2,
   localparam int AW   = $clog2(NREGS)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [NRP*AW-1:0]   raddr_i,
   output logic [NRP*XLEN-1:0] rdata_o,
   output logic [NRP-1:0]      busy_o,
   input  logic                we_i,
   input  logic [AW-1:0]       waddr_i,
   input  logic [XLEN-1:0]     wdata_i,
   input  logic                issue_i,
   input  logic [AW-1:0]       issue_rd_i,
   input  logic                dbg_req_i,
   input  logic                dbg_we_i,
   input  logic [AW-1:0]       dbg_addr_i,
   input  logic [XLEN-1:0]     dbg_wdata_i,
   output logic                dbg_ack_o,
   output logic [XLEN-1:0]     dbg_rdata_o
);

   typedef struct packed {
      logic            we;
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] wdata;
   } dbg_req_t;

   logic [XLEN-1:0] regs [NREGS];
   dbg_state_e      state, state_nxt;
   dbg_req_t        dbg_q;
   logic [XLEN-1:0] dbg_rdata_q;
   logic            dbg_wr_fire;

   // x0 and out-of-range addresses always read zero.
   function automatic logic [XLEN-1:0] rd_reg(input logic [AW-1:0] a);
      if (a == '0 || !addr_ok(int'(a), NREGS))
         return '0;
      return regs[a];
   endfunction

   // Debug writes only use cycles the core leaves free.
   assign dbg_wr_fire = (state == DBG_WAIT) && dbg_q.we && !we_i;

   // ---------------- storage ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (we_i) begin
         if (waddr_i != '0 && addr_ok(int'(waddr_i), NREGS))
            regs[waddr_i] <= wdata_i;
      end else if (dbg_wr_fire) begin
         if (dbg_q.addr != '0 && addr_ok(int'(dbg_q.addr), NREGS))
            regs[dbg_q.addr] <= dbg_q.wdata;
      end
   end

   // ---------------- read ports ----------------
   for (genvar k = 0; k < NRP; k++) begin : g_rp
      logic [AW-1:0] ra;
      assign ra = raddr_i[k*AW +: AW];
`ifdef GPR_BYPASS_EN
      assign rdata_o[k*XLEN +: XLEN] =
         (we_i && waddr_i == ra && ra != '0 && addr_ok(int'(ra), NREGS)) ?
         wdata_i : rd_reg(ra);
`else
      assign rdata_o[k*XLEN +: XLEN] = rd_reg(ra);
`endif
   end

   // ---------------- scoreboard ----------------
   gpr_scoreboard #(
      .NREGS (NREGS),
      .NRP   (NRP)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .issue_i    (issue_i),
      .issue_rd_i (issue_rd_i),
      .we_i       (we_i),
      .waddr_i    (waddr_i),
      .raddr_i    (raddr_i),
      .busy_o     (busy_o)
   );

   // ---------------- debug FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= DBG_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DBG_IDLE: if (dbg_req_i)              state_nxt = DBG_WAIT;
         DBG_WAIT: if (!dbg_q.we || !we_i)     state_nxt = DBG_DONE;
         DBG_DONE:                             state_nxt = DBG_IDLE;
         default:                              state_nxt = DBG_IDLE;
      endcase
   end

   always_comb begin
      dbg_ack_o   = (state == DBG_DONE);
      dbg_rdata_o = dbg_rdata_q;
   end

   // Request fields are latched on acceptance so the requester's bus may
   // move on once ack is seen; read data stays until the next read.
   always_ff @(posedge clk) begin
      if (rst) begin
         dbg_q       <= '0;
         dbg_rdata_q <= '0;
      end else begin
         if (state == DBG_IDLE && dbg_req_i)
            dbg_q <= '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i};
         if (state == DBG_WAIT && !dbg_q.we)
            dbg_rdata_q <= rd_reg(dbg_q.addr);
      end
   end

endmodule

// File: tb/tb_gpr_file_mp.sv
`timescale 1ns/1ps
module tb_gpr_file_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRP   = 2;
   localparam int AW    = 5;
`ifdef GPR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [NRP*AW-1:0]   raddr_i;
   logic [NRP*XLEN-1:0] rdata_o;
   logic [NRP-1:0]      busy_o;
   logic                we_i;
   logic [AW-1:0]       waddr_i;
   logic [XLEN-1:0]     wdata_i;
   logic                issue_i;
   logic [AW-1:0]       issue_rd_i;
   logic                dbg_req_i;
   logic                dbg_we_i;
   logic [AW-1:0]       dbg_addr_i;
   logic [XLEN-1:0]     dbg_wdata_i;
   logic                dbg_ack_o;
   logic [XLEN-1:0]     dbg_rdata_o;

   logic [AW-1:0]       rp [NRP];

   always #5 clk = ~clk;

   always_comb begin
      raddr_i = '0;
      for (int k = 0; k < NRP; k++) raddr_i[k*AW +: AW] = rp[k];
   end

   gpr_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
      .clk         (clk),
      .rst         (rst),
      .raddr_i     (raddr_i),
      .rdata_o     (rdata_o),
      .busy_o      (busy_o),
      .we_i        (we_i),
      .waddr_i     (waddr_i),
      .wdata_i     (wdata_i),
      .issue_i     (issue_i),
      .issue_rd_i  (issue_rd_i),
      .dbg_req_i   (dbg_req_i),
      .dbg_we_i    (dbg_we_i),
      .dbg_addr_i  (dbg_addr_i),
      .dbg_wdata_i (dbg_wdata_i),
      .dbg_ack_o   (dbg_ack_o),
      .dbg_rdata_o (dbg_rdata_o)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [XLEN-1:0] m_regs [NREGS];
   bit              m_pend [NREGS];
   logic [XLEN-1:0] m_dbg_rdata;
   bit              m_out;        // a debug access is accepted and not yet performed
   bit              m_op_we;
   logic [AW-1:0]   m_op_addr;
   logic [XLEN-1:0] m_op_wdata;
   int              m_ack_cyc;    // cycle in which ack must be high
   int              m_idle_at;    // first cycle a new request can be accepted
   int              cyc = 0;
   bit              chk_en = 1'b0;
   bit              ack_seen;

   task automatic model_update();
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
         end
         m_out = 1'b0; m_ack_cyc = -1; m_idle_at = 0; m_dbg_rdata = '0;
         return;
      end
      if (!m_out) begin
         if (cyc >= m_idle_at && dbg_req_i) begin
            m_out = 1'b1; m_op_we = dbg_we_i; m_op_addr = dbg_addr_i; m_op_wdata = dbg_wdata_i;
         end
      end else if (!m_op_we || !we_i) begin
         // Debug reads see the value stored before this edge's core write.
         if (!m_op_we) m_dbg_rdata = m_regs[m_op_addr];
         else if (m_op_addr != 0) m_regs[m_op_addr] = m_op_wdata;
         m_out = 1'b0; m_ack_cyc = cyc + 1; m_idle_at = cyc + 2;
      end
      if (we_i && waddr_i != 0) m_regs[waddr_i] = wdata_i;
      if (we_i) m_pend[waddr_i] = 1'b0;
      if (issue_i && issue_rd_i != 0) m_pend[issue_rd_i] = 1'b1;
   endtask

   // One clock: check outputs at the falling edge, advance the model at the rising edge.
   task automatic cycle();
      logic [AW-1:0]   a;
      logic [XLEN-1:0] e_rd;
      bit              byp_hit, e_bz;
      @(negedge clk);
      ack_seen = dbg_ack_o;
      if (chk_en) begin
         for (int k = 0; k < NRP; k++) begin
            a       = rp[k];
            byp_hit = BYP && we_i && waddr_i == a && a != 0;
            e_rd    = (a == 0) ? '0 : byp_hit ? wdata_i : m_regs[a];
            e_bz    = byp_hit ? (issue_i && issue_rd_i == a) : m_pend[a];
            chk($sformatf("rdata%0d_x%0d_c%0d", k, a, cyc), rdata_o[k*XLEN +: XLEN], e_rd);
            chk($sformatf("busy%0d_x%0d_c%0d", k, a, cyc), XLEN'(busy_o[k]), XLEN'(e_bz));
         end
         chk($sformatf("dbg_ack_c%0d", cyc), XLEN'(dbg_ack_o), XLEN'(cyc == m_ack_cyc));
         chk($sformatf("dbg_rdata_c%0d", cyc), dbg_rdata_o, m_dbg_rdata);
      end
      @(posedge clk);
      model_update();
      #1;
      cyc++;
   endtask

   // Debug access with nstall cycles of core writeback right after the request.
   task automatic dbg_access(input bit we, input logic [AW-1:0] addr,
                             input logic [XLEN-1:0] wdata, input int nstall, output int lat);
      dbg_req_i = 1'b1; dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wdata;
      lat = 0;
      cycle();
      while (!ack_seen && lat < 20) begin
         lat++;
         we_i = (lat <= nstall);
         waddr_i = AW'(10 + lat);
         wdata_i = $urandom;
         cycle();
      end
      we_i = 1'b0; dbg_req_i = 1'b0;
      chk("dbg_ack_within_bound", XLEN'(ack_seen), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      int acks;
      rst = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0; issue_i = 1'b0; issue_rd_i = '0;
      dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
      for (int k = 0; k < NRP; k++) rp[k] = '0;
      cycle(); cycle();
      rst = 1'b0; chk_en = 1'b1;

      // Reset state on every register through every port.
      for (int a = 0; a < NREGS; a += NRP) begin
         for (int k = 0; k < NRP; k++) rp[k] = AW'(a + k);
         cycle();
      end

      // Writeback with same-cycle read of the target.
      rp[0] = 5; rp[1] = 5;
      we_i = 1'b1; waddr_i = 5; wdata_i = 32'hDEADBEEF;
      cycle();
      we_i = 1'b0;
      cycle();
      chk("x5_after_write", rdata_o[XLEN-1:0], 32'hDEADBEEF);

      // Issue x7, writeback three cycles later.
      rp[0] = 7; rp[1] = 7;
      issue_i = 1'b1; issue_rd_i = 7;
      cycle();
      issue_i = 1'b0;
      cycle(); cycle();
      we_i = 1'b1; waddr_i = 7; wdata_i = 32'h77;
      cycle();
      we_i = 1'b0;
      cycle();
      chk("x7_busy_cleared", XLEN'(busy_o[0]), 0);
      // Issue and writeback x7 in the same cycle: still pending.
      issue_i = 1'b1; issue_rd_i = 7; we_i = 1'b1; waddr_i = 7; wdata_i = 32'h78;
      cycle();
      issue_i = 1'b0; we_i = 1'b0;
      cycle();
      chk("x7_set_wins", XLEN'(busy_o[1]), 1);
      we_i = 1'b1; waddr_i = 7; wdata_i = 32'h79;
      cycle();
      we_i = 1'b0;
      cycle();

      // x0 writes from core and debug are discarded.
      rp[0] = 0; rp[1] = 0;
      we_i = 1'b1; waddr_i = 0; wdata_i = 32'h1234;
      cycle();
      we_i = 1'b0;
      cycle();
      dbg_access(1'b1, 0, 32'h1234, 0, lat);
      cycle();
      chk("x0_reads_zero", rdata_o[XLEN-1:0], 0);

      // Debug write stalled by three cycles of core writeback.
      dbg_access(1'b1, 9, 32'hA5A5A5A5, 3, lat);
      chk("dbg_wr_stall_latency", XLEN'(lat), 5);
      rp[0] = 9; rp[1] = 11;
      cycle();
      chk("x9_debug_written", rdata_o[XLEN-1:0], 32'hA5A5A5A5);
      rp[0] = 12; rp[1] = 13;
      cycle();

      // Debug read of x3.
      we_i = 1'b1; waddr_i = 3; wdata_i = 32'h55;
      cycle();
      we_i = 1'b0;
      dbg_access(1'b0, 3, '0, 0, lat);
      chk("dbg_rd_latency", XLEN'(lat), 2);
      chk("dbg_rd_data", dbg_rdata_o, 32'h55);

      // Reset while the access sits in WAIT: no ack, FSM back to idle.
      dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 4; dbg_wdata_i = 32'h44;
      we_i = 1'b0;
      cycle();
      we_i = 1'b1; waddr_i = 20; wdata_i = 32'h1;
      rst = 1'b1; dbg_req_i = 1'b0;
      cycle();
      rst = 1'b0; we_i = 1'b0;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (ack_seen) acks++;
      end
      chk("rst_abort_no_ack", XLEN'(acks), 0);
      dbg_access(1'b0, 4, '0, 0, lat);
      chk("rst_abort_idle_latency", XLEN'(lat), 2);
      chk("rst_abort_no_write", dbg_rdata_o, 0);

      // Randomised traffic on all ports.
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NRP; k++) rp[k] = AW'($urandom_range(0, NREGS - 1));
         we_i       = ($urandom_range(0, 1) == 1);
         waddr_i    = AW'($urandom_range(0, NREGS - 1));
         wdata_i    = $urandom;
         issue_i    = ($urandom_range(0, 3) == 0);
         issue_rd_i = AW'($urandom_range(0, NREGS - 1));
         if (!dbg_req_i) begin
            if ($urandom_range(0, 5) == 0) begin
               dbg_req_i = 1'b1; dbg_we_i = ($urandom_range(0, 1) == 1);
               dbg_addr_i = AW'($urandom_range(0, NREGS - 1)); dbg_wdata_i = $urandom;
            end
         end else if (m_ack_cyc == cyc - 1) begin
            if ($urandom_range(0, 3) != 0) dbg_req_i = 1'b0;
            else begin
               dbg_we_i = ($urandom_range(0, 1) == 1);
               dbg_addr_i = AW'($urandom_range(0, NREGS - 1)); dbg_wdata_i = $urandom;
            end
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
